// File: rtl/conv_result_streamer.sv
// Serialises one Conv2d output channel (wide parallel result bus) into a
// pixel-per-beat valid/ready stream tagged with channel, row and column.
module conv_result_streamer #(
  parameter int N          = 24,
  parameter int h          = 8,
  parameter int w          = 40,
  parameter int p          = 1,
  parameter int outchannel = 256,
  localparam int HO  = h - 2 + 2 * p,
  localparam int WO  = w - 2 + 2 * p,
  localparam int PIX = HO * WO,
  localparam int CW  = (outchannel > 1) ? $clog2(outchannel) : 1,
  localparam int RW  = (HO > 1) ? $clog2(HO) : 1,
  localparam int CLW = (WO > 1) ? $clog2(WO) : 1,
  localparam int KW  = (PIX > 1) ? $clog2(PIX) : 1
) (
  input  logic             clk,
  input  logic             global_rst,
  input  logic [N*PIX-1:0] result,
  input  logic [CW-1:0]    res_ch,
  input  logic             res_valid,
  output logic             res_ready,
  output logic [N-1:0]     m_data,
  output logic [CW-1:0]    m_ch,
  output logic [RW-1:0]    m_row,
  output logic [CLW-1:0]   m_col,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last_ch,
  output logic             m_last,
  output logic             busy
);

  logic             act_full_q, act_full_d;
  logic             pend_full_q, pend_full_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CLW-1:0]   col_q, col_d;
  logic [N*PIX-1:0] abuf_q, pbuf_q;
  logic [CW-1:0]    ach_q, pch_q;

  logic fire, last_beat, cap, cap_to_act, cap_to_pend, promote;

  assign fire        = act_full_q & m_ready;
  assign last_beat   = fire & (cnt_q == KW'(PIX - 1));
  assign cap         = res_valid & ~pend_full_q;
  // The retiring cycle frees the active slot, so a capture can land there directly.
  assign cap_to_act  = cap & (~act_full_q | last_beat);
  assign cap_to_pend = cap & act_full_q & ~last_beat;
  assign promote     = last_beat & pend_full_q;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    act_full_d  = act_full_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    if (fire) begin
      if (last_beat) begin
        cnt_d       = '0;
        row_d       = '0;
        col_d       = '0;
        act_full_d  = pend_full_q | cap_to_act;
        pend_full_d = 1'b0;
      end else begin
        cnt_d = cnt_q + KW'(1);
        if (col_q == CLW'(WO - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CLW'(1);
        end
      end
    end
    if (cap_to_act)  act_full_d  = 1'b1;
    if (cap_to_pend) pend_full_d = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      act_full_q  <= 1'b0;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      act_full_q  <= act_full_d;
      pend_full_q <= pend_full_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  // NOTE: the wide buffers carry no reset; the full flags alone qualify them.
  always_ff @(posedge clk) begin
    if (cap_to_act) begin
      abuf_q <= result;
      ach_q  <= res_ch;
    end else if (promote) begin
      abuf_q <= pbuf_q;
      ach_q  <= pch_q;
    end
    if (cap_to_pend) begin
      pbuf_q <= result;
      pch_q  <= res_ch;
    end
  end

  assign res_ready = ~pend_full_q;
  assign m_valid   = act_full_q;
  assign m_data    = abuf_q[32'(cnt_q) * N +: N];
  assign m_ch      = ach_q;
  assign m_row     = row_q;
  assign m_col     = col_q;
  assign m_last_ch = act_full_q & (cnt_q == KW'(PIX - 1));
  assign m_last    = m_last_ch & (ach_q == CW'(outchannel - 1));
  assign busy      = act_full_q | pend_full_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench: small 2x2 instance for protocol corners, default-size
// instance for full-frame row/column wrap.
module tb_conv_result_streamer;

  localparam int N = 24;

  logic clk = 1'b0;
  logic global_rst;
  always #5 clk = ~clk;

  // Small instance: h=4, w=4, p=0 -> 2x2 output, PIX=4
  logic [4*N-1:0] result;
  logic [7:0]     res_ch;
  logic           res_valid, res_ready;
  logic [N-1:0]   m_data;
  logic [7:0]     m_ch;
  logic [0:0]     m_row, m_col;
  logic           m_valid, m_ready, m_last_ch, m_last, busy;

  conv_result_streamer #(.N(N), .h(4), .w(4), .p(0), .outchannel(256)) dut (
    .clk(clk), .global_rst(global_rst),
    .result(result), .res_ch(res_ch), .res_valid(res_valid), .res_ready(res_ready),
    .m_data(m_data), .m_ch(m_ch), .m_row(m_row), .m_col(m_col),
    .m_valid(m_valid), .m_ready(m_ready), .m_last_ch(m_last_ch), .m_last(m_last),
    .busy(busy)
  );

  // Default instance: 8x40 output, PIX=320
  logic [320*N-1:0] d_result;
  logic [7:0]       d_res_ch;
  logic             d_res_valid, d_res_ready;
  logic [N-1:0]     d_m_data;
  logic [7:0]       d_m_ch;
  logic [2:0]       d_m_row;
  logic [5:0]       d_m_col;
  logic             d_m_valid, d_m_ready, d_m_last_ch, d_m_last, d_busy;

  conv_result_streamer dut_dflt (
    .clk(clk), .global_rst(global_rst),
    .result(d_result), .res_ch(d_res_ch), .res_valid(d_res_valid), .res_ready(d_res_ready),
    .m_data(d_m_data), .m_ch(d_m_ch), .m_row(d_m_row), .m_col(d_m_col),
    .m_valid(d_m_valid), .m_ready(d_m_ready), .m_last_ch(d_m_last_ch), .m_last(d_m_last),
    .busy(d_busy)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4*N-1:0] mk4(input logic [N-1:0] base);
    logic [4*N-1:0] r;
    for (int k = 0; k < 4; k++) r[N*k +: N] = base + N'(k);
    return r;
  endfunction

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [23:0] data;
    logic        row;
    logic        col;
    logic        lst;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers;
    int errs;

    // Expected backpressure trace: m_ready pattern 1,0,0,1,1,0,1 then idle
    vecs[0] = '{1'b1, 1'b1, 24'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 24'd2, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 24'd2, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 24'd2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 24'd3, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 24'd4, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 24'd4, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0};

    global_rst  = 1'b0;
    result      = '0;
    res_ch      = '0;
    res_valid   = 1'b0;
    m_ready     = 1'b0;
    d_result    = '0;
    d_res_ch    = '0;
    d_res_valid = 1'b0;
    d_m_ready   = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_ready", 64'(res_ready), 64'd1);
    check("rst_m_last_ch", 64'(m_last_ch), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_row_col", 64'({m_row, m_col}), 64'd0);
    global_rst = 1'b1;

    // Single channel
    @(negedge clk);
    m_ready = 1'b1; res_valid = 1'b1; res_ch = 8'd3; result = mk4(24'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      res_valid = 1'b0;
      check($sformatf("single_valid%0d", k), 64'(m_valid), 64'd1);
      check($sformatf("single_data%0d", k), 64'(m_data), 64'(k + 1));
      check($sformatf("single_rowcol%0d", k), 64'({m_row, m_col}), 64'(k));
      check($sformatf("single_ch%0d", k), 64'(m_ch), 64'd3);
      check($sformatf("single_lastch%0d", k), 64'(m_last_ch), 64'(k == 3));
      check($sformatf("single_last%0d", k), 64'(m_last), 64'd0);
    end
    @(negedge clk);
    check("single_valid_fall", 64'(m_valid), 64'd0);
    check("single_busy_fall", 64'(busy), 64'd0);

    // Backpressure, table-driven
    res_valid = 1'b1; res_ch = 8'd3; result = mk4(24'd1);
    xfers = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      res_valid = 1'b0;
      m_ready   = vecs[i].rdy;
      check($sformatf("bp_valid%0d", i), 64'(m_valid), 64'(vecs[i].vld));
      if (vecs[i].vld) begin
        check($sformatf("bp_data%0d", i), 64'(m_data), 64'(vecs[i].data));
        check($sformatf("bp_rowcol%0d", i), 64'({m_row, m_col}), 64'({vecs[i].row, vecs[i].col}));
        check($sformatf("bp_lastch%0d", i), 64'(m_last_ch), 64'(vecs[i].lst));
      end
      if (m_valid && m_ready) xfers++;
    end
    check("bp_xfer_count", 64'(xfers), 64'd4);

    // Pipelined channels 5 -> 6, then simultaneous retire/capture of 7
    m_ready = 1'b1;
    res_valid = 1'b1; res_ch = 8'd5; result = mk4(24'h10);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      res_valid = 1'b0;
      if (i == 0) begin res_valid = 1'b1; res_ch = 8'd6; result = mk4(24'h20); end
      if (i == 7) begin res_valid = 1'b1; res_ch = 8'd7; result = mk4(24'h30); end
      check($sformatf("pipe_valid%0d", i), 64'(m_valid), 64'd1);
      check($sformatf("pipe_data%0d", i), 64'(m_data),
            (i < 4) ? 64'(24'h10 + i) : (i < 8) ? 64'(24'h20 + i - 4) : 64'(24'h30 + i - 8));
      check($sformatf("pipe_ch%0d", i), 64'(m_ch), (i < 4) ? 64'd5 : (i < 8) ? 64'd6 : 64'd7);
      check($sformatf("pipe_res_ready%0d", i), 64'(res_ready), 64'((i == 0) || (i >= 4)));
    end
    @(negedge clk);
    check("pipe_valid_fall", 64'(m_valid), 64'd0);
    check("pipe_busy_fall", 64'(busy), 64'd0);

    // Last channel of the layer on the small instance
    res_valid = 1'b1; res_ch = 8'd255; result = mk4(24'hA0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      res_valid = 1'b0;
      check($sformatf("lastch_m_last%0d", k), 64'(m_last), 64'(k == 3));
      check($sformatf("lastch_m_last_ch%0d", k), 64'(m_last_ch), 64'(k == 3));
    end

    // Full default-size frame on channel 255
    @(negedge clk);
    for (int k = 0; k < 320; k++) d_result[N*k +: N] = N'(k + 1);
    d_res_valid = 1'b1; d_res_ch = 8'd255; d_m_ready = 1'b1;
    errs = 0;
    for (int k = 0; k < 320; k++) begin
      @(negedge clk);
      d_res_valid = 1'b0;
      if (d_m_valid !== 1'b1 || d_m_data !== N'(k + 1) || d_m_row !== 3'(k / 40) ||
          d_m_col !== 6'(k % 40) || d_m_last !== (k == 319) || d_m_ch !== 8'd255)
        errs++;
      if (k == 319) begin
        check("dflt_end_row", 64'(d_m_row), 64'd7);
        check("dflt_end_col", 64'(d_m_col), 64'd39);
        check("dflt_end_last", 64'({d_m_last, d_m_last_ch}), 64'd3);
      end
    end
    check("dflt_beat_errors", 64'(errs), 64'd0);
    @(negedge clk);
    check("dflt_valid_fall", 64'(d_m_valid), 64'd0);

    // Asynchronous reset mid-stream with pending full
    res_valid = 1'b1; res_ch = 8'd1; result = mk4(24'h40);
    @(negedge clk);
    res_ch = 8'd2; result = mk4(24'h50);
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_pre_data", 64'(m_data), 64'h42);
    check("rst_mid_pre_ready", 64'(res_ready), 64'd0);
    #1 global_rst = 1'b0;
    #1;
    check("rst_mid_valid", 64'(m_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_ready", 64'(res_ready), 64'd1);
    @(negedge clk);
    global_rst = 1'b1;
    @(negedge clk);
    check("rst_mid_idle", 64'(m_valid), 64'd0);
    res_valid = 1'b1; res_ch = 8'd9; result = mk4(24'h60);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      res_valid = 1'b0;
      check($sformatf("post_rst_data%0d", k), 64'(m_data), 64'(24'h60 + k));
      check($sformatf("post_rst_ch%0d", k), 64'(m_ch), 64'd9);
    end
    @(negedge clk);
    check("post_rst_valid_fall", 64'(m_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/conv_result_streamer.md
# conv_result_streamer

Drains the wide, parallel output bus of one Conv2d output channel and emits it as a pixel-by-pixel valid/ready stream tagged with channel, row and column. It sits directly after the Conv2d engine, on the opposite side of the result bus from the per-channel weight/bias sequencing. It turns the `N*(h-2+2p)*(w-2+2p)`-bit result vector into one N-bit Q-format word per beat. A two-entry buffer (active + pending) lets the engine hand over channel k+1 while channel k is still streaming.

## Interface
Derived constants: `HO = h-2+2*p`, `WO = w-2+2*p`, `PIX = HO*WO`, `CW = $clog2(outchannel)`.

Parameters:
- `N`, 24, pixel word width; passed through unmodified.
- `h`, 8, input feature-map height.
- `w`, 40, input feature-map width.
- `p`, 1, padding.
- `outchannel`, 256, number of output channels per layer.

Ports:
- `clk`  in  1  single clock, rising edge.
- `global_rst`  in  1  asynchronous, active-low reset.
- `result`  in  N*PIX  Conv2d result bus; pixel k = row*WO+col is at `[N*k +: N]`.
- `res_ch`  in  CW  channel index accompanying `result`.
- `res_valid`  in  1  result bus holds a complete channel.
- `res_ready`  out  1  block can accept a channel.
- `m_data`  out  N  current pixel.
- `m_ch`  out  CW  channel of current pixel.
- `m_row`  out  $clog2(HO)  row of current pixel.
- `m_col`  out  $clog2(WO)  column of current pixel.
- `m_valid`  out  1  stream beat valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_last_ch`  out  1  last pixel of the channel (k = PIX-1).
- `m_last`  out  1  `m_last_ch` and `m_ch == outchannel-1`.
- `busy`  out  1  active or pending buffer occupied.

## Operation
- Storage consists of two buffers: active (`abuf`, `ach`, `act_full`) and pending (`pbuf`, `pch`, `pend_full`). There is a pixel counter `cnt` (0..PIX-1) plus `row`/`col` counters that wrap with it.
- `res_ready = !pend_full`. A capture occurs on `res_valid && res_ready` and latches the whole `result` bus and `res_ch` in one edge.
- Capture target:
  - If `act_full == 0`, the capture goes to active.
  - Otherwise, if the current cycle retires the last active beat (`m_valid && m_ready && cnt == PIX-1`), the capture goes to active directly.
  - Otherwise the capture goes to pending.
- Retire rules when a beat transfers (`m_valid && m_ready`):
  - If `cnt < PIX-1`: increment `cnt`. `col` increments; at `WO-1`, `col` wraps to 0 and `row` increments.
  - If `cnt == PIX-1` and `pend_full`: move pending to active and clear `pend_full`. `cnt`, `row` and `col` reset to 0, and `act_full` stays 1.
  - If `cnt == PIX-1` with no pending and no same-cycle capture: clear `act_full`.
- Outputs:
  - `m_valid = act_full`.
  - `m_data = abuf[N*cnt +: N]`, `m_ch = ach`, `m_row = row`, `m_col = col`.
  - `busy = act_full | pend_full`.
- `res_ch` is not range-checked. Values `>= outchannel` stream normally with `m_last = 0`.
- The block performs no arithmetic on pixel data: bit-exact pass-through, no ReLU, no rounding.

## Timing
- Reset (`global_rst = 0`, asynchronous):
  - `act_full`, `pend_full`, `cnt`, `row`, `col` clear to 0, so `m_valid = 0`, `busy = 0`, `m_last_ch = 0`, `m_last = 0`, `m_row = m_col = 0`.
  - `res_ready = 1`.
  - Buffer contents are don't-care.
  - Reset mid-stream drops both buffers without emitting further beats.
- Latency: a capture at edge T gives `m_valid = 1` with pixel 0 from T+1.
- With `m_ready` held high, one pixel per cycle. PIX beats per channel.
- Back-to-back channels have zero bubble cycles whenever pending is filled before the last beat retires. The direct-to-active capture on the retiring cycle is also bubble-free.
- Stream outputs hold stable while `m_valid && !m_ready`.
- `res_ready` depends only on registered state, with no combinational path from `res_valid`. `m_*` outputs likewise have no combinational path from `m_ready`.
- The upstream must hold `result` and `res_ch` stable only during the capture cycle.

## Test plan
- Use `h=4, w=4, p=0` (HO=WO=2, PIX=4) unless noted.
- Single channel: `result` pixels 0x000001..0x000004 (k=0..3), `res_ch=3`, `m_ready=1`.
  - Required: 4 consecutive beats with data 1,2,3,4.
  - (row,col) = (0,0),(0,1),(1,0),(1,1), `m_ch=3`.
  - `m_last_ch` only on beat 4, `m_last=0`.
  - `m_valid` falls the next cycle and `busy` returns to 0.
- Backpressure: same data with `m_ready` pattern 1,0,0,1,1,0,1.
  - Required: `m_data`, `m_row`, `m_col` hold during the 0 cycles.
  - Exactly 4 transfers, in order, with no duplicates.
- Pipelined channels: capture ch 5 (data 0x10..0x13), then ch 6 (0x20..0x23) one cycle later.
  - Required: `res_ready=0` after the second capture.
  - 8 consecutive beats with no gap.
  - `m_ch` switches 5→6 at beat 5.
  - `res_ready` returns to 1 on the cycle after beat 4.
- Simultaneous retire and capture: pending empty; present `res_valid` with ch 7 on the exact cycle beat 4 of ch 6 transfers.
  - Required: accepted.
  - Next cycle shows ch 7 pixel 0 with `m_valid=1` and `pend_full` still 0.
- Last channel: `res_ch = outchannel-1 = 255`.
  - Required: `m_last=1` and `m_last_ch=1` together on beat 4 only.
  - Repeat with default parameters (PIX=320): `m_row`/`m_col` end at (7,39).
- Reset mid-stream: assert `global_rst=0` asynchronously after beat 2 with pending full.
  - Required: `m_valid=0`, `busy=0`, `res_ready=1` immediately, with no clock edge needed.
  - After release, a fresh capture streams from pixel 0.
